// File: rtl/bram_port_controller.sv
// BRAM port controller: zero-fills the BRAM after reset or clear, then serves
// registered read/write requests through a credit-limited, in-order response FIFO.
module bram_port_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_CLEAR,
  input  logic                  i_REQ_VALID,
  output logic                  o_REQ_READY,
  input  logic                  i_REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0] i_REQ_ADDRESS,
  input  logic [DATA_WIDTH-1:0] i_REQ_DATA,
  output logic                  o_RSP_VALID,
  input  logic                  i_RSP_READY,
  output logic [DATA_WIDTH-1:0] o_RSP_DATA,
  output logic                  o_WRITE_ENABLE,
  output logic [ADDR_WIDTH-1:0] o_WRITE_ADDRESS,
  output logic [DATA_WIDTH-1:0] o_WRITE_DATA,
  output logic                  o_READ_ENABLE,
  output logic [ADDR_WIDTH-1:0] o_READ_ADDRESS,
  input  logic [DATA_WIDTH-1:0] i_READ_DATA,
  output logic                  o_INIT_DONE
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Extra counter bit marks the cycle after the last zero write.
  localparam logic [ADDR_WIDTH:0] INIT_END = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW:0]         CREDITS  = (CW+1)'(RSP_DEPTH);

  logic [0:0]            state;
  logic [ADDR_WIDTH:0]   init_cnt;
  logic                  rd_stage2;
  logic [CW-1:0]         fifo_count;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic [CW:0]           credit_used;
  logic                  accept;
  logic                  push;
  logic                  pop;

  // Credits cover both buffered responses and reads still in the BRAM pipeline.
  assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(o_READ_ENABLE) + (CW+1)'(rd_stage2);
  assign o_INIT_DONE = (state == ST_RUN);
  assign o_REQ_READY = o_INIT_DONE && (credit_used < CREDITS);
  assign accept      = i_REQ_VALID && o_REQ_READY;
  assign push        = rd_stage2;
  assign o_RSP_VALID = (fifo_count != '0);
  assign pop         = o_RSP_VALID && i_RSP_READY;
  assign o_RSP_DATA  = o_RSP_VALID ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state           <= ST_INIT;
      init_cnt        <= '0;
      o_WRITE_ENABLE  <= 1'b0;
      o_WRITE_ADDRESS <= '0;
      o_WRITE_DATA    <= '0;
      o_READ_ENABLE   <= 1'b0;
      o_READ_ADDRESS  <= '0;
      rd_stage2       <= 1'b0;
      fifo_count      <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
    end else begin
      o_WRITE_ENABLE <= 1'b0;
      o_READ_ENABLE  <= 1'b0;
      rd_stage2      <= o_READ_ENABLE;

      if (state == ST_INIT) begin
        if (init_cnt == INIT_END) begin
          state <= ST_RUN;
        end else begin
          o_WRITE_ENABLE  <= 1'b1;
          o_WRITE_ADDRESS <= init_cnt[ADDR_WIDTH-1:0];
          o_WRITE_DATA    <= '0;
          init_cnt        <= init_cnt + 1'b1;
        end
      end else begin
        if (accept) begin
          if (i_REQ_WRITE) begin
            o_WRITE_ENABLE  <= 1'b1;
            o_WRITE_ADDRESS <= i_REQ_ADDRESS;
            o_WRITE_DATA    <= i_REQ_DATA;
          end else begin
            o_READ_ENABLE  <= 1'b1;
            o_READ_ADDRESS <= i_REQ_ADDRESS;
          end
        end
        if (i_CLEAR) begin
          state    <= ST_INIT;
          init_cnt <= '0;
        end
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge i_CLK) begin
    if (push) fifo_mem[wr_ptr] <= i_READ_DATA;
  end

endmodule
